snitch_icache_refill_server: RTL and testbench
==============================================

SNITCH_ICACHE_REFILL_SERVER -- requirements
Module: snitch_icache_refill_server

Interface
REQ-001 SHALL have parameter LINE_WIDTH, default 128, cache line bits; power of two, multiple of MEM_DW.
REQ-002 SHALL have parameter FILL_AW, default 32, refill/memory byte-address width.
REQ-003 SHALL have parameter MEM_DW, default 32, memory word bits; power of two, at least 8.
REQ-004 SHALL have parameter ID_WIDTH, default 2, refill ID width (matches config PENDING_IW).
REQ-005 SHALL have ports:
  clk_i  in  1  clock, rising edge;
  rst_ni  in  1  reset, synchronous, active-low;
  refill_req_addr_i  in  FILL_AW  requested line byte address;
  refill_req_id_i  in  ID_WIDTH  refill ID;
  refill_req_valid_i  in  1  request valid;
  refill_req_ready_o  out  1  request ready;
  refill_rsp_data_o  out  LINE_WIDTH  assembled line;
  refill_rsp_error_o  out  1  any beat errored;
  refill_rsp_id_o  out  ID_WIDTH  echoed ID;
  refill_rsp_valid_o  out  1  response valid;
  refill_rsp_ready_i  in  1  response ready;
  mem_req_o  out  1  memory word request;
  mem_addr_o  out  FILL_AW  word byte address;
  mem_gnt_i  in  1  request granted;
  mem_rvalid_i  in  1  read data valid, in grant order;
  mem_rdata_i  in  MEM_DW  read data;
  mem_err_i  in  1  read error, qualified by mem_rvalid_i.

Function
REQ-006 SHALL define BEATS = LINE_WIDTH/MEM_DW and LINE_OFF = log2(LINE_WIDTH/8).
REQ-007 SHALL implement FSM IDLE -> FETCH -> RESP -> IDLE.
REQ-008 IDLE: refill_req_ready_o=1; on valid&ready, latch ID, latch base = addr with low LINE_OFF bits zeroed, clear data and error, and enter FETCH.
REQ-009 FETCH: mem_req_o=1 while issue_cnt<BEATS, with mem_addr_o = base + issue_cnt*(MEM_DW/8) (modulo 2^FILL_AW); issue_cnt increments on mem_req_o&mem_gnt_i.
REQ-010 mem_req_o and mem_addr_o SHALL stay stable until granted; multiple grants may be outstanding (maximum BEATS).
REQ-011 On mem_rvalid_i in FETCH: store mem_rdata_i at bits [recv_cnt*MEM_DW +: MEM_DW], OR mem_err_i into the sticky error, and increment recv_cnt.
REQ-012 When the beat with recv_cnt==BEATS-1 is received, SHALL enter RESP on the next cycle.
REQ-013 An error SHALL NOT abort the fetch; all BEATS beats are issued and received.
REQ-014 RESP: refill_rsp_valid_o=1 with data, error and ID held stable until refill_rsp_ready_i; on handshake, enter IDLE.
REQ-015 refill_req_ready_o SHALL be 0 outside IDLE; a new request is accepted no earlier than the cycle after the response handshake.
REQ-016 mem_rvalid_i outside FETCH SHALL be ignored.
REQ-017 Latency, with gnt every cycle and rvalid one cycle after gnt: request accepted at cycle 0, mem_req_o at cycles 1..BEATS, refill_rsp_valid_o first high at cycle BEATS+2.
REQ-018 Counters SHALL be log2(BEATS)+1 bits wide and SHALL NOT wrap within a line.

Reset
REQ-019 While rst_ni=0 at a rising edge: FSM=IDLE, counters=0, data/error/ID/base=0.
REQ-020 Reset values: refill_req_ready_o=1; refill_rsp_valid_o=0; mem_req_o=0; mem_addr_o=0; refill_rsp_data_o=0; refill_rsp_error_o=0; refill_rsp_id_o=0.
REQ-021 Reset mid-FETCH or mid-RESP SHALL abandon the line; stale memory responses after reset are ignored per REQ-016.

Structure
REQ-022 Refill request and response struct typedefs (addr/id; data/error/id) SHALL be added to snitch_icache_pkg; BEATS and LINE_OFF SHALL be local parameters.
REQ-023 SHALL be a single flat module with no sub-modules; the FSM and both counters are inline.

Verification (LINE_WIDTH=128, MEM_DW=32, FILL_AW=32, ID_WIDTH=2)
REQ-024 Request addr 0x1000_0014 id 2, gnt always 1, rvalid +1 cycle with data A0,A1,A2,A3 -> mem_addr 0x1000_0010/14/18/1C; rsp data {A3,A2,A1,A0}, id 2, error 0; rsp_valid at cycle 6.
REQ-025 Hold refill_rsp_ready_i=0 for 5 cycles in RESP -> rsp outputs stable, refill_req_ready_o=0; IDLE the cycle after ready.
REQ-026 mem_err_i=1 on beat 2 only -> 4 requests still issued; rsp error=1; data for beats 0, 1, 3 correct.
REQ-027 mem_gnt_i=0 for 3 cycles on beat 1 -> mem_req_o=1 and mem_addr_o=0x1000_0014 held stable across those cycles; no beat skipped.
REQ-028 rst_ni=0 for one cycle after 2 beats are received, then a stale rvalid -> reset values next cycle, refill_req_ready_o=1, stale beat ignored; next request returns a correct line.

Source files
------------

// File: rtl/snitch_icache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : snitch_icache_pkg
// Description : Shared types for the instruction-cache refill path: refill
//               request/response records and the refill server state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package snitch_icache_pkg;

    // Default refill geometry. The record types below are sized with these.
    localparam int REFILL_LINE_WIDTH = 128;
    localparam int REFILL_FILL_AW    = 32;
    localparam int REFILL_ID_WIDTH   = 2;

    typedef struct packed {
        logic [REFILL_FILL_AW-1:0]  addr;
        logic [REFILL_ID_WIDTH-1:0] id;
    } refill_req_t;

    typedef struct packed {
        logic [REFILL_LINE_WIDTH-1:0] data;
        logic                         error;
        logic [REFILL_ID_WIDTH-1:0]   id;
    } refill_rsp_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_RESP  = 2'd2
    } refill_state_e;

endpackage : snitch_icache_pkg
`default_nettype wire

// File: rtl/snitch_icache_refill_server_if.sv
`default_nettype none
// ============================================================================
// Module      : snitch_icache_refill_server_if
// Description : Bundles the refill request/response handshake and the
//               word-wide memory port of the refill server.
//   slave  : the refill server side (accepts refills, drives memory requests)
//   master : the cache/memory side (issues refills, answers memory requests)
// Revision    : 1.0 - initial release
// ============================================================================
interface snitch_icache_refill_server_if #(
    parameter int LINE_WIDTH = 128,
    parameter int FILL_AW    = 32,
    parameter int MEM_DW     = 32,
    parameter int ID_WIDTH   = 2
);
    logic [FILL_AW-1:0]    req_addr;
    logic [ID_WIDTH-1:0]   req_id;
    logic                  req_valid;
    logic                  req_ready;
    logic [LINE_WIDTH-1:0] rsp_data;
    logic                  rsp_error;
    logic [ID_WIDTH-1:0]   rsp_id;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic                  mem_req;
    logic [FILL_AW-1:0]    mem_addr;
    logic                  mem_gnt;
    logic                  mem_rvalid;
    logic [MEM_DW-1:0]     mem_rdata;
    logic                  mem_err;

    modport slave (
        input  req_addr, req_id, req_valid, rsp_ready,
        input  mem_gnt, mem_rvalid, mem_rdata, mem_err,
        output req_ready, rsp_data, rsp_error, rsp_id, rsp_valid,
        output mem_req, mem_addr
    );

    modport master (
        output req_addr, req_id, req_valid, rsp_ready,
        output mem_gnt, mem_rvalid, mem_rdata, mem_err,
        input  req_ready, rsp_data, rsp_error, rsp_id, rsp_valid,
        input  mem_req, mem_addr
    );
endinterface : snitch_icache_refill_server_if
`default_nettype wire

// File: rtl/snitch_icache_refill_server.sv
`default_nettype none
// ============================================================================
// Module      : snitch_icache_refill_server
// Description : Serves one cache-line refill at a time by splitting it into
//               BEATS word reads on a grant/rvalid memory port, assembling
//               the words into a line and returning it with a sticky error.
// Ports       :
//   clk_i, rst_ni          clock (rising edge), synchronous active-low reset
//   refill_req_*           line request: addr, id, valid/ready
//   refill_rsp_*           line response: data, error, id, valid/ready
//   mem_req_o/mem_addr_o   word request, held until mem_gnt_i
//   mem_rvalid_i/_rdata_i  read data returned in grant order, mem_err_i
// Revision    : 1.0 - initial release
// ============================================================================
module snitch_icache_refill_server
    import snitch_icache_pkg::*;
#(
    parameter int LINE_WIDTH = 128,
    parameter int FILL_AW    = 32,
    parameter int MEM_DW     = 32,
    parameter int ID_WIDTH   = 2
) (
    input  wire logic                  clk_i,
    input  wire logic                  rst_ni,
    input  wire logic [FILL_AW-1:0]    refill_req_addr_i,
    input  wire logic [ID_WIDTH-1:0]   refill_req_id_i,
    input  wire logic                  refill_req_valid_i,
    output logic                       refill_req_ready_o,
    output logic [LINE_WIDTH-1:0]      refill_rsp_data_o,
    output logic                       refill_rsp_error_o,
    output logic [ID_WIDTH-1:0]        refill_rsp_id_o,
    output logic                       refill_rsp_valid_o,
    input  wire logic                  refill_rsp_ready_i,
    output logic                       mem_req_o,
    output logic [FILL_AW-1:0]         mem_addr_o,
    input  wire logic                  mem_gnt_i,
    input  wire logic                  mem_rvalid_i,
    input  wire logic [MEM_DW-1:0]     mem_rdata_i,
    input  wire logic                  mem_err_i
);

    localparam int BEATS    = LINE_WIDTH / MEM_DW;
    localparam int LINE_OFF = $clog2(LINE_WIDTH / 8);
    localparam int CW       = $clog2(BEATS) + 1;

    localparam logic [FILL_AW-1:0] LINE_MASK = ~FILL_AW'((1 << LINE_OFF) - 1);
    localparam logic [FILL_AW-1:0] WORD_STEP = FILL_AW'(MEM_DW / 8);
    localparam logic [CW-1:0]      LAST_BEAT = CW'(BEATS - 1);

    refill_state_e          r_state;
    logic [CW-1:0]          r_issue_cnt;
    logic [CW-1:0]          r_recv_cnt;
    logic [LINE_WIDTH-1:0]  r_data;
    logic                   r_err;
    logic [ID_WIDTH-1:0]    r_id;
    logic                   r_req_ready;
    logic                   r_rsp_valid;
    logic                   r_mem_req;
    logic [FILL_AW-1:0]     r_mem_addr;

    // mem_addr is walked incrementally from the line base, which is the value
    // loaded at accept time; it only advances on a grant, so an ungranted
    // request keeps both req and addr stable.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state     <= S_IDLE;
            r_issue_cnt <= '0;
            r_recv_cnt  <= '0;
            r_data      <= '0;
            r_err       <= 1'b0;
            r_id        <= '0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_addr  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (refill_req_valid_i) begin
                        r_id        <= refill_req_id_i;
                        r_data      <= '0;
                        r_err       <= 1'b0;
                        r_issue_cnt <= '0;
                        r_recv_cnt  <= '0;
                        r_mem_req   <= 1'b1;
                        r_mem_addr  <= refill_req_addr_i & LINE_MASK;
                        r_req_ready <= 1'b0;
                        r_state     <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (r_mem_req && mem_gnt_i) begin
                        r_issue_cnt <= r_issue_cnt + 1'b1;
                        if (r_issue_cnt == LAST_BEAT) begin
                            r_mem_req <= 1'b0;
                        end else begin
                            r_mem_addr <= r_mem_addr + WORD_STEP;
                        end
                    end
                    // Errors are only accumulated; the line is always fetched
                    // in full so the memory side never sees a dangling read.
                    if (mem_rvalid_i) begin
                        for (int b = 0; b < BEATS; b++) begin
                            if (r_recv_cnt == CW'(b)) begin
                                r_data[b*MEM_DW +: MEM_DW] <= mem_rdata_i;
                            end
                        end
                        r_err      <= r_err | mem_err_i;
                        r_recv_cnt <= r_recv_cnt + 1'b1;
                        if (r_recv_cnt == LAST_BEAT) begin
                            r_rsp_valid <= 1'b1;
                            r_state     <= S_RESP;
                        end
                    end
                end
                S_RESP: begin
                    if (refill_rsp_ready_i) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign refill_req_ready_o = r_req_ready;
    assign refill_rsp_data_o  = r_data;
    assign refill_rsp_error_o = r_err;
    assign refill_rsp_id_o    = r_id;
    assign refill_rsp_valid_o = r_rsp_valid;
    assign mem_req_o          = r_mem_req;
    assign mem_addr_o         = r_mem_addr;

endmodule : snitch_icache_refill_server
`default_nettype wire

// File: tb/tb_snitch_icache_refill_server.sv
`default_nettype none
// ============================================================================
// Module      : tb_snitch_icache_refill_server
// Description : Directed bench for the refill server. A word memory answers
//               every granted request one cycle later with data = addr ^
//               0xA5A5_0000; optional grant stalls, a per-address error and an
//               injected stale beat are available per test.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_snitch_icache_refill_server;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    snitch_icache_refill_server_if bus ();

    snitch_icache_refill_server dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .refill_req_addr_i  (bus.req_addr),
        .refill_req_id_i    (bus.req_id),
        .refill_req_valid_i (bus.req_valid),
        .refill_req_ready_o (bus.req_ready),
        .refill_rsp_data_o  (bus.rsp_data),
        .refill_rsp_error_o (bus.rsp_error),
        .refill_rsp_id_o    (bus.rsp_id),
        .refill_rsp_valid_o (bus.rsp_valid),
        .refill_rsp_ready_i (bus.rsp_ready),
        .mem_req_o          (bus.mem_req),
        .mem_addr_o         (bus.mem_addr),
        .mem_gnt_i          (bus.mem_gnt),
        .mem_rvalid_i       (bus.mem_rvalid),
        .mem_rdata_i        (bus.mem_rdata),
        .mem_err_i          (bus.mem_err)
    );

    int checks   = 0;
    int failures = 0;

    // memory model state
    logic        pend      = 1'b0;
    logic [31:0] pend_addr = '0;
    logic [31:0] err_addr  = 32'hFFFF_FFFF;
    logic        inject    = 1'b0;
    int          stall_beat = 0;
    int          stall_left = 0;
    int          n_gnt  = 0;
    int          nreq   = 0;
    int          rv_cnt = 0;
    logic [31:0] gnt_addr [16];
    logic [31:0] req_addr [32];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One cycle: wait for the falling edge, then play the memory for the
    // next rising edge (return last cycle's granted word, decide this grant).
    task automatic step();
        @(negedge clk);
        if (pend) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = pend_addr ^ 32'hA5A5_0000;
            bus.mem_err    = (pend_addr == err_addr);
            rv_cnt++;
        end else if (inject) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = 32'hDEAD_BEEF;
            bus.mem_err    = 1'b1;
            inject         = 1'b0;
        end else begin
            bus.mem_rvalid = 1'b0;
            bus.mem_rdata  = '0;
            bus.mem_err    = 1'b0;
        end
        pend = 1'b0;
        if (bus.mem_req) begin
            if (nreq < 32) req_addr[nreq] = bus.mem_addr;
            nreq++;
            if (stall_left > 0 && n_gnt == stall_beat) begin
                bus.mem_gnt = 1'b0;
                stall_left--;
            end else begin
                bus.mem_gnt = 1'b1;
                pend        = 1'b1;
                pend_addr   = bus.mem_addr;
                if (n_gnt < 16) gnt_addr[n_gnt] = bus.mem_addr;
                n_gnt++;
            end
        end else begin
            bus.mem_gnt = 1'b0;
        end
    endtask

    task automatic start_req(input logic [31:0] a, input logic [1:0] id);
        n_gnt  = 0;
        nreq   = 0;
        rv_cnt = 0;
        bus.req_addr  = a;
        bus.req_id    = id;
        bus.req_valid = 1'b1;
    endtask

    // Present a request and count cycles until the response appears.
    task automatic do_req(input logic [31:0] a, input logic [1:0] id, output int lat);
        start_req(a, id);
        lat = 0;
        do begin
            step();
            lat++;
            if (lat == 1) begin
                bus.req_valid = 1'b0;
                check("busy_ready", 128'(bus.req_ready), 128'(1'b0));
            end
        end while (!bus.rsp_valid && lat < 60);
        if (!bus.rsp_valid) check("rsp_timeout", 128'(bus.rsp_valid), 128'(1'b1));
    endtask

    // Hold the response for 'hold' cycles, then complete the handshake.
    task automatic take_rsp(input int hold);
        logic [127:0] d;
        d = bus.rsp_data;
        for (int i = 0; i < hold; i++) begin
            step();
            check("hold_valid", 128'(bus.rsp_valid), 128'(1'b1));
            check("hold_ready", 128'(bus.req_ready), 128'(1'b0));
            check("hold_data",  bus.rsp_data, d);
        end
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        check("post_valid", 128'(bus.rsp_valid), 128'(1'b0));
        check("post_ready", 128'(bus.req_ready), 128'(1'b1));
    endtask

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_req_ready"}, 128'(bus.req_ready), 128'(1'b1));
        check({pfx, "_rsp_valid"}, 128'(bus.rsp_valid), 128'(1'b0));
        check({pfx, "_mem_req"},   128'(bus.mem_req),   128'(1'b0));
        check({pfx, "_mem_addr"},  128'(bus.mem_addr),  128'(32'h0));
        check({pfx, "_data"},      bus.rsp_data,        128'h0);
        check({pfx, "_error"},     128'(bus.rsp_error), 128'(1'b0));
        check({pfx, "_id"},        128'(bus.rsp_id),    128'(2'd0));
    endtask

    initial begin
        int lat;
        int k;
        bus.req_addr   = '0;
        bus.req_id     = '0;
        bus.req_valid  = 1'b0;
        bus.rsp_ready  = 1'b0;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        bus.mem_err    = 1'b0;

        rst_n = 1'b0;
        repeat (3) step();
        check_reset_vals("rst");
        rst_n = 1'b1;
        step();

        // basic line, unaligned address, long response back-pressure
        do_req(32'h1000_0014, 2'd2, lat);
        check("t1_latency", 128'(lat), 128'(6));
        check("t1_nreq", 128'(nreq), 128'(4));
        check("t1_ngnt", 128'(n_gnt), 128'(4));
        check("t1_addr0", 128'(gnt_addr[0]), 128'(32'h1000_0010));
        check("t1_addr1", 128'(gnt_addr[1]), 128'(32'h1000_0014));
        check("t1_addr2", 128'(gnt_addr[2]), 128'(32'h1000_0018));
        check("t1_addr3", 128'(gnt_addr[3]), 128'(32'h1000_001C));
        check("t1_data", bus.rsp_data, 128'hB5A5001C_B5A50018_B5A50014_B5A50010);
        check("t1_id", 128'(bus.rsp_id), 128'(2'd2));
        check("t1_err", 128'(bus.rsp_error), 128'(1'b0));
        take_rsp(5);

        // error on beat 2 only
        err_addr = 32'h2000_0048;
        do_req(32'h2000_0040, 2'd1, lat);
        check("t2_ngnt", 128'(n_gnt), 128'(4));
        check("t2_err", 128'(bus.rsp_error), 128'(1'b1));
        check("t2_beat0", 128'(bus.rsp_data[31:0]),   128'(32'h85A5_0040));
        check("t2_beat1", 128'(bus.rsp_data[63:32]),  128'(32'h85A5_0044));
        check("t2_beat3", 128'(bus.rsp_data[127:96]), 128'(32'h85A5_004C));
        check("t2_id", 128'(bus.rsp_id), 128'(2'd1));
        take_rsp(0);
        err_addr = 32'hFFFF_FFFF;

        // grant withheld for 3 cycles on beat 1
        stall_beat = 1;
        stall_left = 3;
        do_req(32'h1000_001F, 2'd3, lat);
        check("t3_latency", 128'(lat), 128'(9));
        check("t3_nreq", 128'(nreq), 128'(7));
        check("t3_req0", 128'(req_addr[0]), 128'(32'h1000_0010));
        for (int i = 1; i <= 4; i++) begin
            check("t3_held_addr", 128'(req_addr[i]), 128'(32'h1000_0014));
        end
        check("t3_req5", 128'(req_addr[5]), 128'(32'h1000_0018));
        check("t3_ngnt", 128'(n_gnt), 128'(4));
        check("t3_data", bus.rsp_data, 128'hB5A5001C_B5A50018_B5A50014_B5A50010);
        check("t3_id", 128'(bus.rsp_id), 128'(2'd3));
        take_rsp(0);

        // reset after two beats, then a stale beat while idle
        start_req(32'h3000_0000, 2'd1);
        step();
        bus.req_valid = 1'b0;
        k = 0;
        while (rv_cnt < 2 && k < 20) begin
            step();
            k++;
        end
        check("t4_two_beats", 128'(rv_cnt), 128'(2));
        step();
        rst_n = 1'b0;
        step();
        check_reset_vals("t4_rst");
        rst_n  = 1'b1;
        pend   = 1'b0;
        inject = 1'b1;
        step();
        step();
        check("t4_stale_valid", 128'(bus.rsp_valid), 128'(1'b0));
        check("t4_stale_ready", 128'(bus.req_ready), 128'(1'b1));
        check("t4_stale_data",  bus.rsp_data, 128'h0);
        check("t4_stale_err",   128'(bus.rsp_error), 128'(1'b0));
        check("t4_stale_req",   128'(bus.mem_req), 128'(1'b0));

        do_req(32'h3000_0020, 2'd0, lat);
        check("t4_latency", 128'(lat), 128'(6));
        check("t4_data", bus.rsp_data, 128'h95A5002C_95A50028_95A50024_95A50020);
        check("t4_id", 128'(bus.rsp_id), 128'(2'd0));
        check("t4_err", 128'(bus.rsp_error), 128'(1'b0));
        take_rsp(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_snitch_icache_refill_server
`default_nettype wire
